gray_conv_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one binary-to-Gray conversion datapath (gray = bin ^ (bin >> 1)).
Each requester presents a binary word with a valid/ready handshake. The arbiter grants one requester at a time and converts the word. It buffers the result in a single-entry output register tagged with the source ID, and delivers it downstream with a valid/ready handshake.
The block sits between the code-producing front ends and any consumer of Gray-coded values.

---
 rtl/gray_conv_arbiter.sv | 101 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter in front of one binary-to-Gray converter,
// with a single-entry tagged output register and a completed-handshake counter.
module gray_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_bin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_bin,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             src_q, src_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_hs;
    logic             accept;
    logic             grant_sel;
    logic             xfer;
    logic [WIDTH-1:0] bin_sel;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        out_hs = (state_q == FULL) && out_ready;
        accept = (state_q == EMPTY) || out_hs;

        // On a tie the requester that did not win last time gets the grant.
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end else begin
            grant_sel = 1'b0;
        end

        req0_ready = accept && !grant_sel && req0_valid;
        req1_ready = accept &&  grant_sel && req1_valid;
        xfer       = req0_ready || req1_ready;
        bin_sel    = grant_sel ? req1_bin : req0_bin;
    end

    always_comb begin
        state_d      = state_q;
        gray_d       = gray_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};

        if (xfer) begin
            state_d      = FULL;
            gray_d       = bin2gray(bin_sel);
            src_d        = grant_sel;
            last_grant_d = grant_sel;
        end else if (out_hs) begin
            // Data is left stale on drain; consumers qualify with out_valid.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            gray_q       <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gray_q       <= gray_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_gray   = gray_q;
    assign out_src    = src_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: handshake, alternation, backpressure,
// counter wrap and asynchronous reset, with hand-computed expectations.
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [3:0] req0_bin;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_bin;
    logic       req1_ready;
    logic       out_valid;
    logic [3:0] out_gray;
    logic       out_src;
    logic       out_ready;
    logic [7:0] done_count;

    int n_chk  = 0;
    int n_fail = 0;

    gray_conv_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_bin   (req0_bin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_bin   (req1_bin),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_gray   (out_gray),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_bin   = 4'b0000;
        req1_valid = 1'b0;
        req1_bin   = 4'b0000;
        out_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_gray", out_gray, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_done", done_count, 0);
        chk("rst_rdy0_idle", req0_ready, 0);
        chk("rst_rdy1_idle", req1_ready, 0);
        rst_n = 1'b1;

        // Single transfer from requester 0
        @(negedge clk);
        req0_valid = 1'b1;
        req0_bin   = 4'b0111;
        out_ready  = 1'b1;
        #1;
        chk("t1_rdy0", req0_ready, 1);
        chk("t1_rdy1", req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_gray", out_gray, 4'b0100);
        chk("t1_src", out_src, 0);
        chk("t1_done0", done_count, 0);
        @(posedge clk);
        #1;
        chk("t1_done1", done_count, 1);
        chk("t1_drained", out_valid, 0);

        // Both valid every cycle; last grant was 0, so order is 1,0,1,0
        @(negedge clk);
        req0_valid = 1'b1;
        req0_bin   = 4'b1111;
        req1_valid = 1'b1;
        req1_bin   = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("t2_rdy0", req0_ready, (i % 2 == 1) ? 1 : 0);
            chk("t2_rdy1", req1_ready, (i % 2 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            chk("t2_valid", out_valid, 1);
            chk("t2_src", out_src, (i % 2 == 0) ? 1 : 0);
            chk("t2_gray", out_gray, (i % 2 == 0) ? 4'b0011 : 4'b1000);
        end
        chk("t2_done", done_count, 4);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t2_drained", out_valid, 0);
        chk("t2_done_end", done_count, 5);

        // Backpressure on requester 1
        @(negedge clk);
        out_ready  = 1'b0;
        req1_valid = 1'b1;
        req1_bin   = 4'b1010;
        #1;
        chk("t3_rdy1_first", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_bin = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("t3_hold_rdy1", req1_ready, 0);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_gray", out_gray, 4'b1111);
            chk("t3_hold_src", out_src, 1);
        end
        chk("t3_hold_done", done_count, 5);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t3_rdy1_second", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        chk("t3_second_valid", out_valid, 1);
        chk("t3_second_gray", out_gray, 4'b0101);
        chk("t3_second_src", out_src, 1);
        chk("t3_second_done", done_count, 6);
        @(posedge clk);
        #1;
        chk("t3_drained", out_valid, 0);
        chk("t3_done_end", done_count, 7);

        // Back-to-back stream on requester 0 through the counter wrap
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req0_bin   = k[3:0];
            @(posedge clk);
            #1;
            chk("t4_gray", out_gray, g(k[3:0]));
            if (k == 249) chk("t4_done_255", done_count, 255);
            if (k == 250) chk("t4_done_wrap", done_count, 0);
        end

        // Load a known result, hold it, then reset asynchronously mid-cycle
        @(negedge clk);
        req0_bin = 4'b0111;
        @(posedge clk);
        #1;
        chk("t5_gray", out_gray, 4'b0100);
        chk("t5_done", done_count, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        #2;
        chk("t5_full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_arst_valid", out_valid, 0);
        chk("t5_arst_gray", out_gray, 0);
        chk("t5_arst_src", out_src, 0);
        chk("t5_arst_done", done_count, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_bin   = 4'b0011;
        req1_valid = 1'b1;
        req1_bin   = 4'b1100;
        out_ready  = 1'b1;
        #1;
        chk("t5_tie_rdy0", req0_ready, 1);
        chk("t5_tie_rdy1", req1_ready, 0);
        @(posedge clk);
        #1;
        chk("t5_tie_src", out_src, 0);
        chk("t5_tie_gray", out_gray, 4'b0010);
        @(negedge clk);
        #1;
        chk("t5_next_rdy1", req1_ready, 1);
        @(posedge clk);
        #1;
        chk("t5_next_src", out_src, 1);
        chk("t5_next_gray", out_gray, 4'b1010);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
